count_serializer: RTL and testbench

//   Downstream consumer of the 128-bit free-running counter. A snapshot pulse

---
 rtl/count_serializer.sv | 105 ++++++++++
 tb/tb_count_serializer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/count_serializer.sv
// Captures a snapshot of a wide counter and streams it out LSB byte first over a
// valid/ready byte link; snapshot requests arriving mid-frame are only counted.
module count_serializer #(
    parameter int unsigned WIDTH  = 128,
    parameter int unsigned DROP_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [WIDTH-1:0]  count_i,
    input  logic              snap_i,
    output logic              busy_o,
    output logic [7:0]        tx_data_o,
    output logic              tx_valid_o,
    input  logic              tx_ready_i,
    output logic              tx_last_o,
    output logic [DROP_W-1:0] drop_cnt_o
);

    localparam int unsigned NBytes = WIDTH / 8;
    localparam int unsigned IdxW   = (NBytes > 1) ? $clog2(NBytes) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NBytes - 1);

    if ((WIDTH % 8) != 0 || WIDTH < 8) begin : g_width_check
        $error("count_serializer: WIDTH must be a multiple of 8 and at least 8");
    end

    typedef enum logic [0:0] {StIdle, StSend} state_e;

    state_e              r_state, w_state_d;
    logic [WIDTH-1:0]    r_shadow, w_shadow_d;
    logic [IdxW-1:0]     r_idx, w_idx_d, w_idx_inc;
    logic [7:0]          r_data, w_data_d;
    logic                r_last, w_last_d;
    logic [DROP_W-1:0]   r_drop, w_drop_d;
    logic [7:0]          w_bytes [NBytes];
    logic                w_xfer, w_final, w_capture, w_drop;

    always_comb begin
        for (int b = 0; b < int'(NBytes); b++) begin
            w_bytes[b] = r_shadow[8*b +: 8];
        end
    end

    assign w_xfer    = (r_state == StSend) && tx_ready_i;
    assign w_final   = w_xfer && r_last;
    // The final-transfer edge counts as free, so a snap there starts the next frame.
    assign w_capture = snap_i && ((r_state == StIdle) || w_final);
    assign w_drop    = snap_i && (r_state == StSend) && !w_final;
    assign w_idx_inc = r_idx + 1'b1;

    always_comb begin
        w_state_d  = r_state;
        w_shadow_d = r_shadow;
        w_idx_d    = r_idx;
        w_data_d   = r_data;
        w_last_d   = r_last;
        w_drop_d   = r_drop;

        if (w_capture) begin
            w_state_d  = StSend;
            w_shadow_d = count_i;
            w_idx_d    = '0;
            w_data_d   = count_i[7:0];
            w_last_d   = (NBytes == 1);
        end else if (w_final) begin
            w_state_d = StIdle;
            w_idx_d   = '0;
            w_data_d  = 8'h00;
            w_last_d  = 1'b0;
        end else if (w_xfer) begin
            w_idx_d  = w_idx_inc;
            w_data_d = w_bytes[w_idx_inc];
            w_last_d = (w_idx_inc == LastIdx);
        end

        if (w_drop && (r_drop != {DROP_W{1'b1}})) begin
            w_drop_d = r_drop + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state  <= StIdle;
            r_shadow <= '0;
            r_idx    <= '0;
            r_data   <= 8'h00;
            r_last   <= 1'b0;
            r_drop   <= '0;
        end else begin
            r_state  <= w_state_d;
            r_shadow <= w_shadow_d;
            r_idx    <= w_idx_d;
            r_data   <= w_data_d;
            r_last   <= w_last_d;
            r_drop   <= w_drop_d;
        end
    end

    assign busy_o     = (r_state == StSend);
    assign tx_valid_o = (r_state == StSend);
    assign tx_data_o  = r_data;
    assign tx_last_o  = r_last;
    assign drop_cnt_o = r_drop;

endmodule

// File: tb/tb_count_serializer.sv
// Bench for count_serializer: randomized stimulus checked against a byte-queue model
// of the frame in flight plus a saturating drop counter.
module tb_count_serializer;

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic [127:0] count_i;
    logic         snap_i;
    logic         busy_o;
    logic [7:0]   tx_data_o;
    logic         tx_valid_o;
    logic         tx_ready_i;
    logic         tx_last_o;
    logic [7:0]   drop_cnt_o;

    int errors = 0;
    int checks = 0;

    // Model: bytes still to be sent in the current frame, and expected drop count.
    logic [7:0] exp_q [$];
    int         m_drop = 0;

    count_serializer #(
        .WIDTH  (128),
        .DROP_W (8)
    ) u_dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .count_i    (count_i),
        .snap_i     (snap_i),
        .busy_o     (busy_o),
        .tx_data_o  (tx_data_o),
        .tx_valid_o (tx_valid_o),
        .tx_ready_i (tx_ready_i),
        .tx_last_o  (tx_last_o),
        .drop_cnt_o (drop_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [18:0] exp_vec();
        logic v;
        v = (exp_q.size() != 0);
        return {v, v, exp_q.size() == 1, v ? exp_q[0] : 8'h00, 8'(m_drop)};
    endfunction

    // Data is only meaningful while valid, so it is masked otherwise.
    function automatic logic [18:0] obs_vec();
        return {busy_o, tx_valid_o, tx_last_o, tx_valid_o ? tx_data_o : 8'h00, drop_cnt_o};
    endfunction

    // Drive one cycle from a negedge, advance the model at the posedge, return at the negedge.
    task automatic drive(input logic snap, input logic rdy, input logic [127:0] cnt);
        logic       v, fin;
        logic [7:0] tmp;
        snap_i     = snap;
        tx_ready_i = rdy;
        count_i    = cnt;
        @(posedge clk_i);
        v   = (exp_q.size() != 0);
        fin = 1'b0;
        if (v && rdy) begin
            tmp = exp_q.pop_front();
            fin = (exp_q.size() == 0);
        end
        if (snap) begin
            if (!v || fin) begin
                for (int b = 0; b < 16; b++) exp_q.push_back(cnt[8*b +: 8]);
            end else if (m_drop < 255) begin
                m_drop++;
            end
        end
        @(negedge clk_i);
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; snap_i = 1'b0; tx_ready_i = 1'b0; count_i = '0;
        #1;
        if ({busy_o, tx_valid_o, tx_last_o, tx_data_o, drop_cnt_o} !== 19'h0) begin
            errors++;
            $display("FAIL reset got=%h want=0",
                     {busy_o, tx_valid_o, tx_last_o, tx_data_o, drop_cnt_o});
        end
        checks++;
        @(negedge clk_i);
        rst_ni = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, rand128());
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL reset_idle cyc=%0d got=%h want=%h", i, obs_vec(), exp_vec());
            end
            checks++;
        end
    endtask

    task automatic test_basic();
        logic [127:0] cnt;
        for (int b = 0; b < 16; b++) cnt[8*b +: 8] = 8'(b);
        drive(1'b1, 1'b1, cnt);
        for (int i = 0; i < 17; i++) begin
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL basic cyc=%0d got=%h want=%h", i, obs_vec(), exp_vec());
            end
            checks++;
            if (i < 16 && (tx_data_o !== 8'(i) || tx_last_o !== (i == 15))) begin
                errors++;
                $display("FAIL basic_byte idx=%0d got=%h/%b want=%h/%b",
                         i, tx_data_o, tx_last_o, 8'(i), i == 15);
            end
            if (i < 16) checks++;
            drive(1'b0, 1'b1, rand128());
        end
    endtask

    task automatic test_stall();
        int  xfers = 0;
        logic rdy;
        drive(1'b1, 1'b0, rand128());
        for (int c = 0; c < 200 && exp_q.size() != 0; c++) begin
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL stall cyc=%0d got=%h want=%h", c, obs_vec(), exp_vec());
            end
            checks++;
            rdy = (c % 4 == 0) || (c % 4 == 3);
            if (rdy && tx_valid_o) xfers++;
            drive(1'b0, rdy, rand128());
        end
        if (xfers !== 16 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL stall_xfers got=%0d want=16 (model left %0d)", xfers, exp_q.size());
        end
        checks++;
        if (obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL stall_end got=%h want=%h", obs_vec(), exp_vec());
        end
        checks++;
    endtask

    task automatic test_drops();
        drive(1'b1, 1'b1, rand128());
        for (int i = 0; i < 16; i++) begin
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL drops cyc=%0d got=%h want=%h", i, obs_vec(), exp_vec());
            end
            checks++;
            drive(i == 2 || i == 6 || i == 11, 1'b1, rand128());
        end
        if (drop_cnt_o !== 8'd3 || tx_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL drops_cnt got=%0d/%b want=3/0", drop_cnt_o, tx_valid_o);
        end
        checks++;
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 1'b1, rand128());
        for (int i = 0; i < 16; i++) begin
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL b2b cyc=%0d got=%h want=%h", i, obs_vec(), exp_vec());
            end
            checks++;
            drive(i == 15, 1'b1, (i == 15) ? 128'd5 : rand128());
        end
        if (tx_valid_o !== 1'b1 || tx_data_o !== 8'h05 || drop_cnt_o !== 8'd3) begin
            errors++;
            $display("FAIL b2b_first got=%b/%h/%0d want=1/05/3", tx_valid_o, tx_data_o, drop_cnt_o);
        end
        checks++;
        for (int i = 0; i < 16; i++) begin
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL b2b_second cyc=%0d got=%h want=%h", i, obs_vec(), exp_vec());
            end
            checks++;
            drive(1'b0, 1'b1, 128'd0);
        end
    endtask

    task automatic test_saturate();
        drive(1'b1, 1'b0, rand128());
        for (int i = 0; i < 300; i++) begin
            drive(1'b1, 1'b0, rand128());
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL sat cyc=%0d got=%h want=%h", i, obs_vec(), exp_vec());
            end
            checks++;
        end
        if (drop_cnt_o !== 8'd255) begin
            errors++;
            $display("FAIL sat_final got=%0d want=255", drop_cnt_o);
        end
        checks++;
        for (int i = 0; i < 16; i++) drive(1'b0, 1'b1, rand128());
        if (obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL sat_drain got=%h want=%h", obs_vec(), exp_vec());
        end
        checks++;
    endtask

    task automatic test_reset_midframe();
        logic [127:0] cnt;
        drive(1'b1, 1'b1, rand128());
        for (int i = 0; i < 8; i++) drive(1'b0, 1'b1, rand128());
        rst_ni = 1'b0;
        #1;
        if ({busy_o, tx_valid_o, tx_last_o, tx_data_o, drop_cnt_o} !== 19'h0) begin
            errors++;
            $display("FAIL midreset got=%h want=0",
                     {busy_o, tx_valid_o, tx_last_o, tx_data_o, drop_cnt_o});
        end
        checks++;
        exp_q.delete();
        m_drop = 0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b1, rand128());
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL midreset_idle cyc=%0d got=%h want=%h", i, obs_vec(), exp_vec());
            end
            checks++;
        end
        cnt = rand128();
        drive(1'b1, 1'b1, cnt);
        if (tx_valid_o !== 1'b1 || tx_data_o !== cnt[7:0]) begin
            errors++;
            $display("FAIL midreset_restart got=%b/%h want=1/%h", tx_valid_o, tx_data_o, cnt[7:0]);
        end
        checks++;
        for (int i = 0; i < 16; i++) begin
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL midreset_frame cyc=%0d got=%h want=%h", i, obs_vec(), exp_vec());
            end
            checks++;
            drive(1'b0, 1'b1, rand128());
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0, rand128());
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random cyc=%0d got=%h want=%h", i, obs_vec(), exp_vec());
            end
            checks++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_drops();
        test_back_to_back();
        test_saturate();
        test_reset_midframe();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
